// File: rtl/mem_stage_pkg.sv
// Shared types and sizing helpers for the memory stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {IDLE, XFER, DONE} mem_state_t;

  localparam int BEATS_DEFAULT = 4;
  localparam int BEAT_CNT_W_DEFAULT = $clog2(BEATS_DEFAULT);

  // A single-beat configuration still needs a 1-bit counter.
  function automatic int beat_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_pack.sv
// Lane select for store data and lane insert for load assembly.
module lane_pack #(
  parameter int DATA_W = 128,
  parameter int BUS_W  = 32,
  parameter int BW     = 2
) (
  input  logic [BW-1:0]     beat,
  input  logic [DATA_W-1:0] store_vec,
  input  logic [DATA_W-1:0] load_vec,
  input  logic [BUS_W-1:0]  rdata,
  output logic [BUS_W-1:0]  wdata,
  output logic [DATA_W-1:0] load_next
);

  localparam int BEATS = DATA_W / BUS_W;

  logic [BUS_W-1:0] lanes [BEATS];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
      assign lanes[gi] = store_vec[gi*BUS_W +: BUS_W];
      assign load_next[gi*BUS_W +: BUS_W] =
        (beat == BW'(gi)) ? rdata : load_vec[gi*BUS_W +: BUS_W];
    end
  endgenerate

  assign wdata = lanes[beat];

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: full-rate passthrough of ALU results, and multi-beat
// vector loads/stores over a narrow req/ack bus with upstream stall.
module mem_access_unit
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int BUS_W  = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  output logic              ex_ready,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BUS_W-1:0]  mem_wdata,
  input  logic              mem_ack,
  input  logic [BUS_W-1:0]  mem_rdata,
  output logic              wb_valid,
  output logic              wb_wen,
  output logic [DATA_W-1:0] wb_data
);

  localparam int BEATS = DATA_W / BUS_W;
  localparam int BW    = beat_cnt_w(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  mem_state_t        state_reg;
  logic [BW-1:0]     beat_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [DATA_W-1:0] store_reg;
  logic [DATA_W-1:0] load_reg;
  logic              is_store_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic              wb_valid_reg;
  logic              wb_wen_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic [DATA_W-1:0] load_next;

  lane_pack #(
    .DATA_W (DATA_W),
    .BUS_W  (BUS_W),
    .BW     (BW)
  ) u_lane_pack (
    .beat      (beat_reg),
    .store_vec (store_reg),
    .load_vec  (load_reg),
    .rdata     (mem_rdata),
    .wdata     (mem_wdata),
    .load_next (load_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      beat_reg     <= '0;
      base_reg     <= '0;
      store_reg    <= '0;
      load_reg     <= '0;
      is_store_reg <= 1'b0;
      mem_req_reg  <= 1'b0;
      mem_we_reg   <= 1'b0;
      wb_valid_reg <= 1'b0;
      wb_wen_reg   <= 1'b0;
      wb_data_reg  <= '0;
    end else begin
      wb_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ex_valid) begin
            if (ex_mem_read || ex_mem_write) begin
              // A store wins when both read and write are flagged.
              base_reg     <= ex_alu_out[ADDR_W-1:0];
              store_reg    <= ex_store_data;
              load_reg     <= '0;
              is_store_reg <= ex_mem_write;
              beat_reg     <= '0;
              mem_req_reg  <= 1'b1;
              mem_we_reg   <= ex_mem_write;
              state_reg    <= XFER;
            end else begin
              wb_data_reg  <= ex_alu_out;
              wb_wen_reg   <= 1'b1;
              wb_valid_reg <= 1'b1;
            end
          end
        end
        XFER: begin
          if (mem_req_reg && mem_ack) begin
            if (!is_store_reg) begin
              load_reg <= load_next;
            end
            if (beat_reg == LAST_BEAT) begin
              mem_req_reg  <= 1'b0;
              mem_we_reg   <= 1'b0;
              wb_valid_reg <= 1'b1;
              wb_wen_reg   <= ~is_store_reg;
              wb_data_reg  <= is_store_reg ? '0 : load_next;
              state_reg    <= DONE;
            end else begin
              beat_reg <= beat_reg + 1'b1;
            end
          end
        end
        DONE: begin
          beat_reg  <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Bus address wraps modulo 2^ADDR_W.
  assign mem_addr = base_reg + ADDR_W'(beat_reg);
  assign mem_req  = mem_req_reg;
  assign mem_we   = mem_we_reg;
  assign stall    = (state_reg != IDLE);
  assign ex_ready = ~stall;
  assign wb_valid = wb_valid_reg;
  assign wb_wen   = wb_wen_reg;
  assign wb_data  = wb_data_reg;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory stage that consumes the execute stage's 128-bit `alu_out` result and `rd2` store operand and performs vector loads and stores over a 32-bit data-memory bus with a req/ack handshake. A 128-bit vector moves as four 32-bit beats. The result is registered toward writeback, and the pipeline is stalled while a transfer is in flight. Non-memory results pass through with one cycle of latency.

## Interface
Parameters:
- `DATA_W`, default 128: vector width.
- `BUS_W`, default 32: memory bus width. `DATA_W` must be a multiple of `BUS_W`.
- `ADDR_W`, default 16: word-address width, taken from `ex_alu_out[ADDR_W-1:0]`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ex_valid` in 1: execute result valid this cycle.
- `ex_alu_out` in `DATA_W`: ALU result. Its low `ADDR_W` bits are the base word address for memory operations.
- `ex_store_data` in `DATA_W`: store operand (`rd2`).
- `ex_mem_read` in 1: load operation.
- `ex_mem_write` in 1: store operation.
- `ex_ready` out 1: unit accepts `ex_valid` this cycle.
- `stall` out 1: hold upstream stages.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write enable.
- `mem_addr` out `ADDR_W`: bus word address.
- `mem_wdata` out `BUS_W`: bus write data.
- `mem_ack` in 1: bus beat complete.
- `mem_rdata` in `BUS_W`: bus read data, valid when `mem_ack`=1.
- `wb_valid` out 1: writeback result valid, one-cycle pulse.
- `wb_wen` out 1: register-file write enable for this result.
- `wb_data` out `DATA_W`: writeback data.

## Operation
- `BEATS` = `DATA_W`/`BUS_W`, which is 4 by default.
- Beat order: beat k carries bits [k*BUS_W +: BUS_W] and uses address `base+k`. The address addition is modulo 2^`ADDR_W`, so it wraps silently (0xFFFF+1 = 0x0000).
- FSM states are IDLE, XFER, DONE.
- IDLE:
  - `ex_ready`=1.
  - On `ex_valid` with no memory operation: register `wb_data`=`ex_alu_out`, `wb_wen`=1, pulse `wb_valid`, stay in IDLE. Back-to-back passthrough runs at full rate.
  - On `ex_valid` with a memory operation: latch base, store data and operation type; clear beat counter; go to XFER.
- Precedence: `ex_mem_write`=1 with `ex_mem_read`=1 is executed as a store. The read is ignored.
- XFER:
  - `mem_req`=1.
  - `mem_we`=1 for stores.
  - `mem_addr`=`base+beat`.
  - `mem_wdata`=store lane[beat].
  - `mem_addr`, `mem_we` and `mem_wdata` stay stable until `mem_ack`.
  - A beat completes on a cycle with `mem_req`&`mem_ack`. For a load, `mem_rdata` is captured into lane[beat] on that edge.
  - If `beat`==`BEATS-1`, go to DONE; otherwise increment `beat`.
  - `mem_ack` while `mem_req`=0 is ignored.
- DONE:
  - `wb_valid`=1 for one cycle.
  - Load: `wb_data`=assembled vector, `wb_wen`=1.
  - Store: `wb_data`=0, `wb_wen`=0.
  - Return to IDLE.
- `stall`=1 in XFER and DONE, 0 in IDLE. `ex_ready`=~`stall`. Upstream holds its inputs while stalled, and the unit ignores `ex_valid` then.
- Reset, whether idle or mid-transfer:
  - State goes to IDLE, beat counter to 0.
  - All outputs go to 0, except `ex_ready`=1.
  - `mem_req` drops immediately (asynchronous).
  - The partial transfer is abandoned and no `wb_valid` is produced.

## Timing
- Passthrough: `ex_valid` sampled at edge N gives `wb_valid`/`wb_data` in cycle N+1.
- Memory op with zero wait states, accepted at edge N:
  - `mem_req` high in cycles N+1..N+4, one beat per cycle.
  - DONE and `wb_valid` in cycle N+5.
  - `ex_ready` high again in cycle N+6.
- Each wait cycle (`mem_req`=1, `mem_ack`=0) adds exactly one cycle. Total latency is 5 + waits.
- `mem_req` never deasserts between beats of one transfer unless reset.
- `wb_valid` is never high for two consecutive cycles from the same memory op.

## Structure
- Shared package `mem_stage_pkg` holds:
  - `mem_state_t` enum {IDLE, XFER, DONE}.
  - `BEATS_DEFAULT`.
  - Localparam helpers for beat-counter width, `$clog2(BEATS)`.
- One natural sub-module, `lane_pack`: selects lane[beat] for write data and inserts `mem_rdata` into lane[beat] of the 128-bit load register. Parameterized by `DATA_W`/`BUS_W`.
- FSM, counter and handshake stay in `mem_access_unit`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle. Expect `mem_req`=0, `wb_valid`=0 and `ex_ready`=1 immediately, and `wb_data`=0.
- Passthrough: three consecutive `ex_valid` with `ex_alu_out`=0x…01, 0x…02, 0x…03 and no memory op. Expect `wb_valid` for 3 cycles with the same values one cycle later, and `stall`=0 throughout.
- Zero-wait load:
  - Stimulus: base 0x0010, memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444; `mem_ack` tied high.
  - Expect addresses 0x10..0x13 and `wb_data`=0x44444444_33333333_22222222_11111111 with `wb_wen`=1 at N+5.
- Store with wait states and wrap:
  - Stimulus: base 0xFFFE, store data 0xDDDD…_CCCC…_BBBB…_AAAA…, `mem_ack` delayed 2 cycles per beat.
  - Expect addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, each held stable with matching lane data.
  - Expect `wb_valid` with `wb_wen`=0 at N+13.
- Read+write both set: expect a store (`mem_we`=1 on all 4 beats) and no load writeback.
- Reset during beat 2 of a load: expect `mem_req` to drop immediately, no `wb_valid`, and a following load to start at beat 0 with the correct address.
